// File: rtl/pixel_fifo_m.sv
// pixel_fifo_m: pixel shift FIFO fed by 8-pixel tile rows, with flip, fine-scroll discard
// and an optional sprite-row merge onto the head entries (define PIXEL_FIFO_MERGE_EN).
//   state      | meaning
//   ST_RUN     | normal load/pull operation
//   ST_DISCARD | silently popping rem_q leading pixels; waits while empty
module pixel_fifo_m #(
    parameter int DEPTH  = 16,
    parameter int PIX_W  = 2,
    parameter int ATTR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       load,
    input  logic [8*PIX_W-1:0]         load_pix,
    input  logic [ATTR_W-1:0]          load_attr,
    input  logic                       load_flip,
    output logic                       load_ready,
    input  logic                       pull,
    output logic                       pull_valid,
    output logic [PIX_W-1:0]           pull_pix,
    output logic [ATTR_W-1:0]          pull_attr,
    input  logic                       disc_start,
    input  logic [2:0]                 disc_n,
    output logic                       discarding,
    input  logic                       merge,
    input  logic [8*PIX_W-1:0]         merge_pix,
    input  logic [ATTR_W-1:0]          merge_attr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_ovf
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {ST_RUN = 1'b0, ST_DISCARD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  pix_q  [DEPTH];
    logic [PIX_W-1:0]  pix_d  [DEPTH];
    logic [ATTR_W-1:0] attr_q [DEPTH];
    logic [ATTR_W-1:0] attr_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        rem_q, rem_d;
    logic              err_q, err_d;
    logic [PIX_W-1:0]  ld_lane [8];
    logic              disc_go, pop, push;
    logic [CW-1:0]     base;
    int                off;

    assign disc_go    = disc_start && (disc_n != 3'd0);
    assign load_ready = (count_q <= CW'(DEPTH - 8));

`ifdef PIXEL_FIFO_MERGE_EN
    logic [PIX_W-1:0] mg_lane [8];
    logic             merge_act;

    assign merge_act  = merge && !flush && !disc_go;
    assign pull_valid = (count_q != '0) && (state_q == ST_RUN) && !merge;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mg_lane[i] = load_flip ? merge_pix[(7-i)*PIX_W +: PIX_W] : merge_pix[i*PIX_W +: PIX_W];
        end
    end
`else
    logic merge_unused;

    assign merge_unused = ^{merge, merge_pix, merge_attr};
    assign pull_valid   = (count_q != '0) && (state_q == ST_RUN);
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ld_lane[i] = load_flip ? load_pix[(7-i)*PIX_W +: PIX_W] : load_pix[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        pix_d   = pix_q;
        attr_d  = attr_q;
        count_d = count_q;
        state_d = state_q;
        rem_d   = rem_q;
        err_d   = err_q;
        pop     = 1'b0;
        push    = 1'b0;
        base    = '0;
        off     = 0;
        if (flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                pix_d[j]  = '0;
                attr_d[j] = '0;
            end
            count_d = '0;
            state_d = ST_RUN;
            rem_d   = 3'd0;
            err_d   = 1'b0;
        end
`ifdef PIXEL_FIFO_MERGE_EN
        else if (merge_act) begin
            // empty slots take the sprite pixel even when transparent; occupied ones only over colour 0
            for (int i = 0; i < 8; i++) begin
                if ((count_q <= CW'(i)) || ((pix_q[i] == '0) && (mg_lane[i] != '0))) begin
                    pix_d[i]  = mg_lane[i];
                    attr_d[i] = merge_attr;
                end
            end
            if (count_q < CW'(8)) count_d = CW'(8);
        end
`endif
        else begin
            pop  = (state_q == ST_DISCARD) ? (count_q != '0) : (pull && pull_valid);
            push = load && load_ready;
            if (load && !load_ready) err_d = 1'b1;
            if (pop) begin
                for (int j = 0; j < DEPTH-1; j++) begin
                    pix_d[j]  = pix_q[j+1];
                    attr_d[j] = attr_q[j+1];
                end
                pix_d[DEPTH-1]  = '0;
                attr_d[DEPTH-1] = '0;
            end
            // the new row lands behind whatever survives this cycle's pop
            base = count_q - CW'(pop);
            if (push) begin
                for (int j = 0; j < DEPTH; j++) begin
                    off = j - int'(base);
                    if (off >= 0 && off < 8) begin
                        pix_d[j]  = ld_lane[off[2:0]];
                        attr_d[j] = load_attr;
                    end
                end
            end
            count_d = count_q + (push ? CW'(8) : CW'(0)) - (pop ? CW'(1) : CW'(0));
            if (disc_go) begin
                state_d = ST_DISCARD;
                rem_d   = disc_n;
            end else if ((state_q == ST_DISCARD) && pop) begin
                rem_d = rem_q - 3'd1;
                if (rem_q == 3'd1) state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                pix_q[j]  <= '0;
                attr_q[j] <= '0;
            end
            count_q <= '0;
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            attr_q  <= attr_d;
            count_q <= count_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign pull_pix   = pix_q[0];
    assign pull_attr  = attr_q[0];
    assign discarding = (state_q == ST_DISCARD);
    assign err_ovf    = err_q;

endmodule

// File: tb/tb_pixel_fifo_m.sv
// tb_pixel_fifo_m: directed and random checks of pixel_fifo_m against a queue-based model.
// Merge scenarios run only when PIXEL_FIFO_MERGE_EN is defined.
module tb_pixel_fifo_m;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, load, load_flip, pull, disc_start, merge;
    logic [15:0] load_pix, merge_pix;
    logic [3:0]  load_attr, merge_attr;
    logic [2:0]  disc_n;
    logic        load_ready, pull_valid, discarding, err_ovf;
    logic [1:0]  pull_pix;
    logic [3:0]  pull_attr;
    logic [4:0]  count;

    pixel_fifo_m #(.DEPTH(DEPTH), .PIX_W(2), .ATTR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .load(load), .load_pix(load_pix),
        .load_attr(load_attr), .load_flip(load_flip), .load_ready(load_ready), .pull(pull),
        .pull_valid(pull_valid), .pull_pix(pull_pix), .pull_attr(pull_attr),
        .disc_start(disc_start), .disc_n(disc_n), .discarding(discarding), .merge(merge),
        .merge_pix(merge_pix), .merge_attr(merge_attr), .count(count), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] p; logic [3:0] a; } ent_t;
    ent_t mq[$];
    bit   m_disc, m_err;
    int   m_rem;
    int   nchk = 0, npass = 0;

    function automatic logic [15:0] pk8(input int v0, v1, v2, v3, v4, v5, v6, v7);
        logic [15:0] r;
        r = {v7[1:0], v6[1:0], v5[1:0], v4[1:0], v3[1:0], v2[1:0], v1[1:0], v0[1:0]};
        return r;
    endfunction

    function automatic logic [1:0] lane(input logic [15:0] r, input int i, input bit flip);
        int k;
        k = flip ? 7 - i : i;
        return 2'((r >> (2*k)) & 16'h3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_disc = 0;
        m_err  = 0;
        m_rem  = 0;
    endtask

    task automatic model_step();
        bit disc_go, ready, pv, pop;
        if (flush) begin
            model_reset();
            return;
        end
        disc_go = disc_start && disc_n != 0;
`ifdef PIXEL_FIFO_MERGE_EN
        if (merge && !disc_go) begin
            for (int i = 0; i < 8; i++) begin
                logic [1:0] l;
                l = lane(merge_pix, i, load_flip);
                if (i >= mq.size()) mq.push_back({l, merge_attr});
                else if (mq[i].p == 0 && l != 0) mq[i] = {l, merge_attr};
            end
            return;
        end
        pv = mq.size() != 0 && !m_disc && !merge;
`else
        pv = mq.size() != 0 && !m_disc;
`endif
        ready = (DEPTH - mq.size()) >= 8;
        pop   = m_disc ? (mq.size() != 0) : (pull && pv);
        if (load && !ready) m_err = 1;
        if (pop) void'(mq.pop_front());
        if (load && ready)
            for (int i = 0; i < 8; i++) mq.push_back({lane(load_pix, i, load_flip), load_attr});
        if (disc_go) begin
            m_disc = 1;
            m_rem  = disc_n;
        end else if (m_disc && pop) begin
            m_rem--;
            if (m_rem == 0) m_disc = 0;
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("load_ready", 32'(load_ready), 32'(n <= DEPTH - 8));
        chk("pull_valid", 32'(pull_valid), 32'(n != 0 && !m_disc));
        chk("pull_pix", 32'(pull_pix), 32'(n != 0 ? mq[0].p : 2'd0));
        chk("pull_attr", 32'(pull_attr), 32'(n != 0 ? mq[0].a : 4'd0));
        chk("discarding", 32'(discarding), 32'(m_disc));
        chk("err_ovf", 32'(err_ovf), 32'(m_err));
    endtask

    task automatic clear_in();
        flush = 0; load = 0; load_flip = 0; pull = 0; disc_start = 0; merge = 0;
        load_pix = '0; merge_pix = '0; load_attr = '0; merge_attr = '0; disc_n = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1 clear_in();
        #1 check_all();
    endtask

    task automatic do_load(input logic [15:0] r, input logic [3:0] a, input bit f);
        load = 1; load_pix = r; load_attr = a; load_flip = f;
        tick();
    endtask

    logic [15:0] exp_row;
    int          ncyc;

    initial begin
        clear_in();
        model_reset();
        rst_n = 0;
        #12 check_all();
        @(negedge clk) rst_n = 1;

        // plain row: pixel 0 leaves first
        do_load(pk8(3,2,1,0,0,1,2,3), 4'd5, 0);
        exp_row = pk8(3,2,1,0,0,1,2,3);
        for (int i = 0; i < 8; i++) begin
            chk("row_pix", 32'(pull_pix), 32'(lane(exp_row, i, 0)));
            chk("row_attr", 32'(pull_attr), 32'd5);
            pull = 1;
            tick();
        end
        chk("drained_valid", 32'(pull_valid), 32'd0);

        // flipped row
        do_load(pk8(0,1,2,3,0,0,0,1), 4'd9, 1);
        exp_row = pk8(1,0,0,0,3,2,1,0);
        for (int i = 0; i < 8; i++) begin
            chk("flip_pix", 32'(pull_pix), 32'(lane(exp_row, i, 0)));
            pull = 1;
            tick();
        end

        // overflow and flush
        do_load(pk8(1,1,1,1,2,2,2,2), 4'd1, 0);
        do_load(pk8(3,3,3,3,1,1,1,1), 4'd2, 0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(load_ready), 32'd0);
        do_load(pk8(2,2,2,2,2,2,2,2), 4'd3, 0);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        flush = 1;
        tick();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_err", 32'(err_ovf), 32'd0);

        // load+pull together: +7 per cycle, sequence continuity checked by the model
        do_load(pk8(0,1,2,3,3,2,1,0), 4'd4, 0);
        load = 1; pull = 1; load_pix = pk8(1,2,3,1,2,3,1,2); load_attr = 4'd6;
        tick();
        chk("ldpull_count", 32'(count), 32'd15);
        for (int i = 0; i < 24; i++) begin
            pull = 1;
            if (mq.size() <= DEPTH - 8) begin
                load = 1; load_pix = 16'($urandom); load_attr = 4'($urandom); load_flip = 1'($urandom);
            end
            tick();
        end
        chk("ldpull_noerr", 32'(err_ovf), 32'd0);

        // fine-scroll discard of 3
        flush = 1;
        tick();
        do_load(pk8(0,1,2,3,0,1,2,3), 4'd3, 0);
        disc_start = 1; disc_n = 3'd3;
        tick();
        ncyc = 0;
        while (discarding && ncyc < 10) begin
            ncyc++;
            tick();
        end
        chk("disc_cycles", 32'(ncyc), 32'd3);
        chk("disc_head", 32'(pull_pix), 32'd3);
        chk("disc_count", 32'(count), 32'd5);

        // async reset mid-discard
        disc_start = 1; disc_n = 3'd4;
        tick();
        tick();
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst_n = 1;

        // discard on empty waits for data
        disc_start = 1; disc_n = 3'd2;
        tick();
        tick();
        tick();
        chk("disc_wait", 32'(discarding), 32'd1);
        do_load(pk8(1,2,3,1,2,3,1,2), 4'd8, 0);
        tick();
        tick();
        chk("disc_wait_head", 32'(pull_pix), 32'd3);

`ifdef PIXEL_FIFO_MERGE_EN
        flush = 1;
        tick();
        do_load(pk8(0,2,0,2,0,0,0,0), 4'd4, 0);
        merge = 1; merge_pix = pk8(1,1,1,1,0,0,0,3); merge_attr = 4'd7;
        tick();
        exp_row = pk8(1,2,1,2,0,0,0,3);
        for (int i = 0; i < 8; i++) begin
            chk("merge_pix", 32'(pull_pix), 32'(lane(exp_row, i, 0)));
            chk("merge_attr", 32'(pull_attr), (i == 0 || i == 2 || i == 7) ? 32'd7 : 32'd4);
            pull = 1;
            tick();
        end
`endif

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            flush      = ($urandom % 50) == 0;
            load       = ($urandom % 3) == 0;
            load_pix   = 16'($urandom);
            load_attr  = 4'($urandom);
            load_flip  = 1'($urandom);
            pull       = ($urandom % 3) != 0;
            disc_start = ($urandom % 20) == 0;
            disc_n     = 3'($urandom);
            merge      = ($urandom % 12) == 0;
            merge_pix  = 16'($urandom);
            merge_attr = 4'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
